arm_multicycle_ctrl: RTL and testbench
======================================

Name: arm_multicycle_ctrl

Overview:
- Control unit for the multicycle ARM datapath.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states and keeps the architectural NZCV flags.
- Gates all write strobes with the condition-code check.
- Drives the mux selects, the ALU operation and the ImmSrc select for the immediate extender: 00 = imm8 data-processing, 01 = imm12 load/store, 10 = branch offset.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]. [5] = I, [4:1] = cmd, [0] = S/L.
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  ALU {N,Z,C,V} for the current cycle.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write strobe.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select. 0 = PC, 1 = ALU result.
- ResultSrc  out  2  result select. 00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUSrcA  out  1  ALU A select. 0 = RD1, 1 = PC.
- ALUSrcB  out  2  ALU B select. 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  extender mode.
- RegSrc  out  2  register read-address selects.
- ALUControl  out  2  ALU op. 00 = add, 01 = sub, 10 = and, 11 = orr.
- Flags  out  4  current NZCV register.
- State  out  4  FSM state, for debug.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9. Unused codes go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 & Funct[5]=0 -> EXECR; Op=00 & Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (unsupported, no strobes).
  - MEMADR: Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECR/EXECI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Latency: DP 4 cycles, LDR 5, STR 4, B 3, unsupported 2.
- Per-state controls (unlisted controls = 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW.
  - MEMWRITE: AdrSrc=1, MemW.
  - EXECR: ALUSrcB=00, ALU decode on.
  - EXECI: ALUSrcB=01, ALU decode on.
  - ALUWB: ResultSrc=00, RegW unless NoWrite.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch.
- ALU decode: when decode is off, ALUControl=00. When on, Funct[4:1] maps as:
  - 0100 ADD -> 00.
  - 0010 SUB -> 01.
  - 0000 AND -> 10.
  - 1100 ORR -> 11.
  - 1010 CMP -> 01 with NoWrite=1.
  - Any other -> 00 with NoWrite=1.
- Combinational from Op/Funct, valid in every state:
  - ImmSrc = Op; Op=11 gives 00.
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01 & ~Funct[0]).
- Condition check:
  - CondEx is evaluated in DECODE from Cond and the Flags register, using the standard ARM table 0000 EQ .. 1110 AL.
  - Cond=1111 evaluates false.
  - CondEx is latched into condex_q on the DECODE->next edge. All later gating uses condex_q, so a flag update in EXECR/EXECI does not affect its own instruction.
- Strobe gating:
  - RegWrite = RegW & condex_q.
  - MemWrite = MemW & condex_q.
  - PCWrite = FETCH | (condex_q & (BRANCH | (RegW & Rd==15 & state==ALUWB/MEMWB))).
- Flag update:
  - At the end of EXECR/EXECI, if Funct[0]=1 & condex_q, then N,Z <= ALUFlags[3:2].
  - C,V <= ALUFlags[1:0] only if cmd is ADD, SUB or CMP.
  - Otherwise Flags hold.
- Reset: on a clock edge with reset=1:
  - state <= FETCH, Flags <= RESET_FLAGS, condex_q <= 0.
  - While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - Reset mid-instruction abandons the instruction with no further strobes.
  - First FETCH strobes occur in the first cycle after reset deasserts.

Test Plan:
1. Reset, then ADD R1 (Cond=1110, Op=00, Funct=001000, Rd=1) -> State 0,1,6,8,0; IRWrite=PCWrite=1 only in FETCH; ALUControl=00 in EXECR; RegWrite=1 only in ALUWB; Flags stay 0000.
2. LDR (Op=01, Funct=011001, Cond=AL) -> State 0,1,2,3,4; ImmSrc=01 and ALUSrcB=01 in MEMADR; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
3. SUBS (Funct=000101) with ALUFlags=0110 in EXECR -> Flags=0110 after EXECR. Then BEQ (Op=10, Cond=0000) -> PCWrite=1 in BRANCH with ImmSrc=10. Repeat with Flags=0000 -> PCWrite=0 in BRANCH, FSM still returns to FETCH.
4. CMP (Funct=010101), ALUFlags=1000 -> ALUControl=01, Flags=1000, RegWrite=0 in ALUWB.
5. STRNE (Cond=0001) with Z=1 -> states 0,1,2,5,0; MemWrite=0 throughout. Then Op=11 -> DECODE->FETCH with no strobes.
6. Assert reset during MEMREAD of an LDR after Flags=1111 -> next state FETCH, Flags=0000, no RegWrite/MemWrite/PCWrite while reset is high.

Source files
------------

// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: multicycle ARM control FSM with NZCV flags and condition-gated strobes
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   Cond, Op, Funct, Rd   instruction fields Instr[31:28], [27:26], [25:20], [15:12]
//   ALUFlags              ALU {N,Z,C,V} for the current cycle
//   PCWrite, MemWrite,    write strobes, gated by the latched condition result
//   RegWrite, IRWrite
//   AdrSrc, ResultSrc,    datapath mux selects
//   ALUSrcA, ALUSrcB
//   ImmSrc, RegSrc        extender mode and register read-address selects
//   ALUControl            ALU operation
//   Flags                 architectural NZCV register
//   State                 FSM state for debug
module arm_multicycle_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state, next;
    logic       condex, condex_q;
    logic       regw, memw, branch, aludec, nowrite, cvupd;
    logic [1:0] alu_op;
    logic [3:0] cmd;
    logic       n, z, c, v;

    assign cmd = Funct[4:1];
    assign {n, z, c, v} = Flags;
    assign State = state;

    always_comb begin
        condex = 1'b0;
        case (Cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = n == v;
            4'b1011: condex = n != v;
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:   next = DECODE;
            DECODE:  next = Op == 2'b01 ? MEMADR :
                            Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) :
                            Op == 2'b10 ? BRANCH : FETCH;
            MEMADR:  next = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: next = MEMWB;
            EXECR:   next = ALUWB;
            EXECI:   next = ALUWB;
            default: next = FETCH;
        endcase
    end

    always_comb begin
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        aludec    = 1'b0;
        case (state)
            FETCH, DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            EXECR:    aludec = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                aludec  = 1'b1;
            end
            ALUWB:    regw = ~nowrite;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // CMP shares the subtract op but never writes a register; unknown commands are inert adds
    always_comb begin
        alu_op  = 2'b00;
        nowrite = 1'b1;
        case (cmd)
            4'b0100: nowrite = 1'b0;
            4'b0010: {alu_op, nowrite} = {2'b01, 1'b0};
            4'b0000: {alu_op, nowrite} = {2'b10, 1'b0};
            4'b1100: {alu_op, nowrite} = {2'b11, 1'b0};
            4'b1010: alu_op = 2'b01;
            default: ;
        endcase
    end

    assign cvupd      = cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010;
    assign ALUControl = aludec ? alu_op : 2'b00;
    assign ImmSrc     = Op == 2'b11 ? 2'b00 : Op;
    assign RegSrc     = {Op == 2'b01 & ~Funct[0], Op == 2'b10};

    // Strobes use the condition latched in DECODE, so an instruction's own flag update cannot gate it
    assign IRWrite  = ~reset & (state == FETCH);
    assign RegWrite = ~reset & regw & condex_q;
    assign MemWrite = ~reset & memw & condex_q;
    assign PCWrite  = ~reset & (state == FETCH | condex_q & (branch |
                      regw & Rd == 4'd15 & (state == ALUWB | state == MEMWB)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            Flags    <= RESET_FLAGS;
            condex_q <= 1'b0;
        end else begin
            state <= next;
            if (state == DECODE) condex_q <= condex;
            if ((state == EXECR || state == EXECI) && Funct[0] && condex_q) begin
                Flags[3:2] <= ALUFlags[3:2];
                if (cvupd) Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed instruction sequences checked against a behavioural model every cycle
module tb_arm_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0] Flags, State;

    arm_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic       chk = 1'b0, chk_mux = 1'b0;
    logic [3:0] e_state, e_strb, e_flags, m_flags = 4'b0000;
    logic [5:0] e_mux, e_dec;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk) begin
        check("state", {4'b0, State}, {4'b0, e_state});
        check("strobes{pc,mem,reg,ir}", {4'b0, PCWrite, MemWrite, RegWrite, IRWrite}, {4'b0, e_strb});
        check("flags", {4'b0, Flags}, {4'b0, e_flags});
        if (chk_mux) begin
            check("mux{adr,res,a,b}", {2'b0, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}, {2'b0, e_mux});
            check("dec{imm,regsrc,alu}", {2'b0, ImmSrc, RegSrc, ALUControl}, {2'b0, e_dec});
        end
    end

    // ARM condition table: even codes test a flag predicate, odd codes invert it; 1111 never passes
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = n == v;
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c == 4'b1111 ? 1'b0 : base ^ c[0];
    endfunction

    function automatic logic [1:0] alu_map(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Runs one instruction from its FETCH cycle; rst_at >= 0 asserts reset during that step of the path
    task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r, input logic [3:0] a, input int rst_at);
        int path[$];
        logic ok, wr, pc, mw, rw, ir;
        logic [3:0] cmd;
        cmd = f[4:1];
        ok = cond_ok(c, m_flags);
        wr = cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
        path = {0, 1};
        if (o == 2'b01) path = f[0] ? {0, 1, 2, 3, 4} : {0, 1, 2, 5};
        if (o == 2'b00) path = {0, 1, f[5] ? 7 : 6, 8};
        if (o == 2'b10) path = {0, 1, 9};
        Cond = c; Op = o; Funct = f; Rd = r;
        for (int k = 0; k < path.size(); k++) begin
            e_state = 4'(path[k]);
            e_flags = m_flags;
            if (k == rst_at) begin
                reset = 1'b1;
                chk_mux = 1'b0;
                e_strb = 4'b0000;
                @(posedge clk); #1;
                m_flags = 4'b0000;
                e_state = 4'd0;
                e_flags = 4'b0000;
                @(posedge clk); #1;
                reset = 1'b0;
                chk_mux = 1'b1;
                return;
            end
            ALUFlags = (path[k] == 6 || path[k] == 7) ? a : ~a;
            {pc, mw, rw, ir} = 4'b0000;
            e_mux = 6'b0_00_0_00;
            case (path[k])
                0: begin e_mux = 6'b0_10_1_10; pc = 1'b1; ir = 1'b1; end
                1: e_mux = 6'b0_10_1_10;
                2: e_mux = 6'b0_00_0_01;
                3: e_mux = 6'b1_00_0_00;
                4: begin e_mux = 6'b0_01_0_00; rw = ok; pc = ok & (r == 4'd15); end
                5: begin e_mux = 6'b1_00_0_00; mw = ok; end
                7: e_mux = 6'b0_00_0_01;
                8: begin rw = ok & wr; pc = ok & wr & (r == 4'd15); end
                9: begin e_mux = 6'b0_10_0_01; pc = ok; end
                default: ;
            endcase
            e_strb = {pc, mw, rw, ir};
            e_dec = {o == 2'b11 ? 2'b00 : o, o == 2'b01 & ~f[0], o == 2'b10,
                     (path[k] == 6 || path[k] == 7) ? alu_map(cmd) : 2'b00};
            @(posedge clk); #1;
            if ((path[k] == 6 || path[k] == 7) && ok && f[0]) begin
                m_flags[3:2] = a[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) m_flags[1:0] = a[1:0];
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        {Cond, Op, Funct, Rd, ALUFlags} = '0;
        repeat (2) @(posedge clk);
        #1;
        {e_state, e_strb, e_flags} = '0;
        chk = 1'b1;
        @(posedge clk); #1;
        check("reset state literal", {4'b0, State}, 8'd0);
        reset = 1'b0;
        chk_mux = 1'b1;

        instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0110, -1);   // ADD R1
        check("add keeps flags literal", {4'b0, Flags}, 8'h00);
        instr(4'b1110, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);   // LDR
        instr(4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0110, -1);   // SUBS
        check("subs flags literal", {4'b0, Flags}, 8'h06);
        instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);   // BEQ taken
        instr(4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0000, -1);   // SUBS -> 0000
        instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, -1);   // BEQ not taken
        instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b1000, -1);   // CMP
        check("cmp flags literal", {4'b0, Flags}, 8'h08);
        instr(4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0100, -1);   // SUBS -> Z=1
        instr(4'b0001, 2'b01, 6'b011000, 4'd4, 4'b0000, -1);   // STRNE suppressed
        instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);   // unsupported
        instr(4'b1110, 2'b00, 6'b111001, 4'd5, 4'b1011, -1);   // ORRS imm: C,V hold
        check("orrs flags literal", {4'b0, Flags}, 8'h08);
        instr(4'b1110, 2'b00, 6'b000000, 4'd15, 4'b0000, -1);  // AND PC
        instr(4'b1110, 2'b00, 6'b000011, 4'd6, 4'b0101, -1);   // unknown cmd with S
        instr(4'b0100, 2'b00, 6'b001000, 4'd7, 4'b0000, -1);   // ADDMI fails
        instr(4'b1010, 2'b00, 6'b001001, 4'd8, 4'b1111, -1);   // ADDSGE -> 1111
        check("adds flags literal", {4'b0, Flags}, 8'h0f);
        instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, 3);   // LDR reset in MEMREAD
        check("reset flags literal", {4'b0, Flags}, 8'h00);
        instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, -1);  // LDR PC
        instr(4'b0000, 2'b00, 6'b000101, 4'd3, 4'b0110, -1);   // SUBSEQ fails, flags hold
        instr(4'b0001, 2'b00, 6'b001001, 4'd9, 4'b0100, -1);   // ADDSNE sets Z, still writes
        check("addsne flags literal", {4'b0, Flags}, 8'h04);
        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
